// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared definitions for the sr_cmd_gen command stage.
//   - FSM state encoding (IDLE / ISSUE / GAP)
//   - default parameter values
//   - arbitration helper used when both commands are pending
package sr_cmd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_GAP_CYCLES      = 1;
    localparam int DEF_SET_PRIORITY    = 1;

    // True when the set command should be issued now. The clear command
    // only loses to set when set has priority.
    function automatic logic pick_set(input logic set_pend,
                                      input logic clr_pend,
                                      input logic set_wins);
        return set_pend && (set_wins || !clr_pend);
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// sr_debounce: one request channel.
//   2-flop synchroniser -> debounce counter -> rising-edge pulse.
// Ports:
//   clk  in  : system clock, rising edge
//   rst  in  : synchronous active-low reset
//   btn  in  : raw asynchronous button level
//   rise out : one-cycle pulse when the debounced level goes 0->1
module sr_debounce
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             lvl_q;
    logic             lvl_d;
    logic             lvl_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter only runs while the synchronised sample disagrees with the
    // accepted level; any agreeing sample restarts it from zero.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn;
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            cnt_q      <= cnt_d;
        end
    end

    assign rise = lvl_q & ~lvl_prev_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: turns two bouncy asynchronous buttons into clean, mutually
// exclusive one-cycle s/r pulses for an SR flip-flop.
// Ports:
//   clk     in  : system clock, rising edge
//   rst     in  : synchronous active-low reset
//   set_btn in  : raw set request
//   clr_btn in  : raw clear request
//   s       out : registered set pulse
//   r       out : registered reset pulse
//   busy    out : high whenever the FSM is not IDLE
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int SET_PRIORITY    = DEF_SET_PRIORITY
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic s,
    output logic r,
    output logic busy
);

    // Keep the gap counter at least one bit wide even when GAP_CYCLES is 0.
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic             set_rise;
    logic             clr_rise;
    logic             set_pend_q, set_pend_d;
    logic             clr_pend_q, clr_pend_d;
    logic [1:0]       state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             busy_q, busy_d;
    logic             do_pick;
    logic             take_set;
    logic             take_clr;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clk  (clk),
        .rst  (rst),
        .btn  (set_btn),
        .rise (set_rise)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk  (clk),
        .rst  (clr_rst_unused_guard(rst)),
        .btn  (clr_btn),
        .rise (clr_rise)
    );

    function automatic logic clr_rst_unused_guard(input logic v);
        return v;
    endfunction

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        s_d       = 1'b0;
        r_d       = 1'b0;
        do_pick   = 1'b0;
        take_set  = 1'b0;
        take_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                do_pick = 1'b1;
            end
            ST_ISSUE: begin
                if (GAP_CYCLES > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end else begin
                    do_pick = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    do_pick = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shared IDLE decision, also used on ISSUE/GAP exit so a pending
        // command goes out without an extra idle cycle.
        if (do_pick) begin
            state_d = ST_IDLE;
            if (pick_set(set_pend_q, clr_pend_q, SET_PRIORITY != 0)) begin
                take_set = 1'b1;
                s_d      = 1'b1;
                state_d  = ST_ISSUE;
            end else if (clr_pend_q) begin
                take_clr = 1'b1;
                r_d      = 1'b1;
                state_d  = ST_ISSUE;
            end
        end

        // A new rise in the same cycle as the grant keeps the flag set.
        set_pend_d = set_rise | (set_pend_q & ~take_set);
        clr_pend_d = clr_rise | (clr_pend_q & ~take_clr);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            gap_cnt_q  <= '0;
            set_pend_q <= 1'b0;
            clr_pend_q <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            set_pend_q <= set_pend_d;
            clr_pend_q <= clr_pend_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
        end
    end

    assign s    = s_q;
    assign r    = r_q;
    assign busy = busy_q;

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
Upstream command stage for the sr_ff storage element. It takes two raw, bouncy, asynchronous request inputs (set button, clear button) and turns them into clean, single-cycle s/r command pulses. s and r are never high together, so the downstream SR flip-flop never sees the forbidden S=R=1 input. The block synchronises, debounces and edge-detects each request, then arbitrates and spaces the resulting commands through a small FSM.

Parameters:
DEBOUNCE_CYCLES, 16, number of consecutive stable synchronised samples required before a level change is accepted (legal range >=2).
GAP_CYCLES, 1, idle cycles forced after every issued pulse (0 allowed).
SET_PRIORITY, 1, 1 means set wins when both commands are pending; 0 means clear wins.
CNT_W (localparam), $clog2(DEBOUNCE_CYCLES), width of the debounce counter.
GAP_W (localparam), $clog2(GAP_CYCLES+1), width of the gap counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset (0 = reset)
set_btn  input  1  raw asynchronous set request, active high
clr_btn  input  1  raw asynchronous clear request, active high
s  output  1  registered set pulse to sr_ff.s, one cycle wide
r  output  1  registered reset pulse to sr_ff.r, one cycle wide
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (rst==0 at a clk edge): all synchroniser flops, debounced levels, counters and pending flags go to 0; FSM goes to IDLE; s=0, r=0, busy=0. Reset clears pending and in-flight commands with no deferred pulse afterwards.
- Sync: each button passes through a 2-flop synchroniser (sync1 -> sync2).
- Debounce, per channel: stable level lvl plus counter cnt.
  - If sync2==lvl, cnt<=0.
  - Otherwise cnt increments. When cnt==DEBOUNCE_CYCLES-1 and sync2 still differs, lvl<=sync2 and cnt<=0.
  - Any sample that matches lvl restarts the count.
- Edge detect: a rising edge of lvl (0->1) sets that channel's pend flag on the next edge. Falling edges generate nothing.
  - A new rising edge while pend is already 1 merges; no second command results.
  - If pend sets and clears in the same cycle, set wins and pend stays 1.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: if any pend is set, go to ISSUE. Select set_pend or clr_pend; if both are set, SET_PRIORITY decides. Drive the chosen output (s or r) to 1 for that ISSUE cycle and clear the chosen pend. The loser stays pending.
  - ISSUE: lasts exactly one cycle. Go to GAP if GAP_CYCLES>0; otherwise apply the IDLE rules directly (back-to-back pulses allowed).
  - GAP: hold for GAP_CYCLES cycles with s=r=0. On exit, apply the IDLE rules (go to ISSUE immediately if a pend is set).
- Invariant: s&r==0 in every cycle. Each output is high for exactly one cycle per accepted press.
- Latency: button held high and stable from the edge that first samples it (edge 1) -> s (or r) high in the cycle after edge DEBOUNCE_CYCLES+4, provided the FSM is IDLE.
- busy = (state != IDLE), registered together with the state.

Decomposition:
- Package sr_cmd_pkg: FSM state encoding (IDLE=2'd0, ISSUE=2'd1, GAP=2'd2), default parameter constants.
- Sub-module sr_debounce (synchroniser + debounce counter + rising-edge pulse out), instantiated once per channel. Parameter: DEBOUNCE_CYCLES.
- The top level holds the pend flags, arbitration and FSM.

Test Plan:
- Reset: hold rst=0 for 3 edges with both buttons high -> s=r=busy=0 throughout; after release, no pulse until the buttons are held for the full debounce time.
- Single set (DEBOUNCE_CYCLES=4): set_btn held high for 12 cycles -> exactly one s pulse, high after edge 8 for one cycle; r stays 0; a held button gives no repeat pulse; release gives no pulse.
- Bounce: set_btn pattern high 2 cycles / low 1 cycle repeated 20 cycles, then low -> no s pulse.
- Simultaneous press (SET_PRIORITY=1, GAP_CYCLES=2): both buttons rise on the same edge -> s after edge 8, r after edge 11, never both high. Repeat with SET_PRIORITY=0 -> r after edge 8, s after edge 11.
- GAP_CYCLES=0 with both pending -> s and r pulses on consecutive cycles (edges 8 and 9).
- Reset mid-operation: assert rst during GAP while clr is pending -> no r pulse after reset release; s=r=busy=0 during reset.
